// File: rtl/seq_det_ctrl.sv
// Serial 4-bit pattern detector with IDLE/RUN control, overlapping Mealy match output
// and an optional saturating match counter (enabled by defining SEQ_DET_COUNT_EN).
module seq_det_ctrl #(
    parameter logic [3:0] DEFAULT_PATTERN = 4'b1011,
    parameter int         CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_pattern,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] match_count,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] pattern;
    logic [2:0] hist;
    logic [1:0] fill;

    // Handshake: a pattern load happens on any edge where cfg_valid && cfg_ready;
    // cfg_ready is high only in IDLE, so a cfg_valid held during RUN is simply not taken.
    assign out = (state == RUN) && in_valid && (fill == 2'd3) && ({hist, in} == pattern);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            pattern   <= DEFAULT_PATTERN;
            hist      <= 3'b000;
            fill      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        pattern <= cfg_pattern;
                    end
                    // stop is ignored here, so start together with stop still starts
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        hist      <= 3'b000;
                        fill      <= 2'd0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        hist <= {hist[1:0], in};
                        if (fill != 2'd3) begin
                            fill <= fill + 2'd1;
                        end
                    end
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Cleared only when a run starts, so the final tally stays readable in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cnt <= '0;
        end else if (out && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule
